// File: rtl/wb_xbar_pkg.sv
// Shared types and constants for the single-master Wishbone splitter.
package wb_xbar_pkg;

    localparam int unsigned MAX_SLV = 16;

    localparam logic [31:0] DEF_UNMAPPED_DATA = 32'hBADA_DD00;
    localparam logic [31:0] DEF_TIMEOUT_DATA  = 32'hDEAD_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    // Index width that stays legal for a single slave.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational base/mask address decoder; lowest matching slave index wins.
module wb_addr_decoder
    import wb_xbar_pkg::*;
#(
    parameter int unsigned           NB_SLV = 4,
    parameter int unsigned           IDX_W  = 2,
    parameter logic [32*MAX_SLV-1:0] ADDR_S = {MAX_SLV{32'h3000_0000}},
    parameter logic [32*MAX_SLV-1:0] MASK_S = {MAX_SLV{32'hFFFF_0000}}
) (
    input  logic [31:0]       adr,
    output logic              hit,
    output logic [NB_SLV-1:0] onehot,
    output logic [IDX_W-1:0]  idx
);

    always_comb begin
        hit    = 1'b0;
        onehot = '0;
        idx    = '0;
        for (int i = 0; i < NB_SLV; i++) begin
            if (!hit && ((adr & MASK_S[32*i +: 32]) == (ADDR_S[32*i +: 32] & MASK_S[32*i +: 32]))) begin
                hit       = 1'b1;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wishbone_1mst_to_nslv.sv
// One Wishbone master to NB_SLV slaves with registered request path and error termination.
// Optional slave-ack timeout is built when WB_XBAR_TIMEOUT_EN is defined.
module wishbone_1mst_to_nslv
    import wb_xbar_pkg::*;
#(
    parameter int unsigned           NB_SLV        = 4,
    parameter logic [32*MAX_SLV-1:0] ADDR_S        = {MAX_SLV{32'h3000_0000}},
    parameter logic [32*MAX_SLV-1:0] MASK_S        = {MAX_SLV{32'hFFFF_0000}},
    parameter int unsigned           TIMEOUT       = 255,
    parameter logic [31:0]           UNMAPPED_DATA = DEF_UNMAPPED_DATA,
    parameter logic [31:0]           TIMEOUT_DATA  = DEF_TIMEOUT_DATA
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wbs_m_cyc_i,
    input  logic                  wbs_m_stb_i,
    input  logic                  wbs_m_we_i,
    input  logic [31:0]           wbs_m_adr_i,
    input  logic [31:0]           wbs_m_dat_i,
    input  logic [3:0]            wbs_m_sel_i,
    output logic                  wbs_m_ack_o,
    output logic                  wbs_m_err_o,
    output logic [31:0]           wbs_m_dat_o,
    output logic [NB_SLV-1:0]     wbs_s_cyc_o,
    output logic [NB_SLV-1:0]     wbs_s_stb_o,
    output logic                  wbs_s_we_o,
    output logic [31:0]           wbs_s_adr_o,
    output logic [31:0]           wbs_s_dat_o,
    output logic [3:0]            wbs_s_sel_o,
    input  logic [32*NB_SLV-1:0]  wbs_s_dat_i,
    input  logic [NB_SLV-1:0]     wbs_s_ack_i,
    output logic                  err_irq
);

    localparam int unsigned IDX_W = idx_width(NB_SLV);

    if (NB_SLV < 1 || NB_SLV > MAX_SLV || TIMEOUT < 2) begin : g_cfg_check
        $error("wishbone_1mst_to_nslv: NB_SLV must be 1..16 and TIMEOUT >= 2");
    end

    wb_state_e          state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NB_SLV-1:0]  slv_cyc_q, slv_cyc_d;
    logic               we_q, we_d;
    logic [31:0]        adr_q, adr_d;
    logic [31:0]        wdat_q, wdat_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        m_dat_q, m_dat_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               irq_q, irq_d;

    logic               dec_hit;
    logic [NB_SLV-1:0]  dec_onehot;
    logic [IDX_W-1:0]   dec_idx;
    logic               slv_ack;
    logic [31:0]        slv_rdat;
    logic               tmo_hit;

    wb_addr_decoder #(
        .NB_SLV (NB_SLV),
        .IDX_W  (IDX_W),
        .ADDR_S (ADDR_S),
        .MASK_S (MASK_S)
    ) u_dec (
        .adr    (wbs_m_adr_i),
        .hit    (dec_hit),
        .onehot (dec_onehot),
        .idx    (dec_idx)
    );

`ifdef WB_XBAR_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] timer_q, timer_d;

    assign tmo_hit = (timer_q == TMR_W'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Mux ack and read data of the latched slave.
    always_comb begin
        slv_ack  = 1'b0;
        slv_rdat = '0;
        for (int i = 0; i < NB_SLV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slv_ack  = wbs_s_ack_i[i];
                slv_rdat = wbs_s_dat_i[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        slv_cyc_d = slv_cyc_q;
        we_d      = we_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        sel_d     = sel_q;
        m_dat_d   = m_dat_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        irq_d     = 1'b0;
`ifdef WB_XBAR_TIMEOUT_EN
        timer_d   = timer_q;
`endif
        case (state_q)
            IDLE: begin
                if (wbs_m_cyc_i && wbs_m_stb_i) begin
                    we_d   = wbs_m_we_i;
                    adr_d  = wbs_m_adr_i;
                    wdat_d = wbs_m_dat_i;
                    sel_d  = wbs_m_sel_i;
                    if (dec_hit) begin
                        idx_d     = dec_idx;
                        slv_cyc_d = dec_onehot;
`ifdef WB_XBAR_TIMEOUT_EN
                        timer_d   = '0;
`endif
                        state_d   = BUSY;
                    end else begin
                        m_dat_d = UNMAPPED_DATA;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        irq_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            BUSY: begin
                if (!wbs_m_cyc_i) begin
                    slv_cyc_d = '0;
                    state_d   = IDLE;
                end else if (slv_ack) begin
                    m_dat_d   = slv_rdat;
                    slv_cyc_d = '0;
                    ack_d     = 1'b1;
                    state_d   = RESP;
                end else if (tmo_hit) begin
                    m_dat_d   = TIMEOUT_DATA;
                    slv_cyc_d = '0;
                    ack_d     = 1'b1;
                    err_d     = 1'b1;
                    irq_d     = 1'b1;
                    state_d   = RESP;
                end else begin
`ifdef WB_XBAR_TIMEOUT_EN
                    if (timer_q != {TMR_W{1'b1}}) begin
                        timer_d = timer_q + TMR_W'(1);
                    end
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                slv_cyc_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            slv_cyc_q <= '0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            wdat_q    <= '0;
            sel_q     <= '0;
            m_dat_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
`ifdef WB_XBAR_TIMEOUT_EN
            timer_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            slv_cyc_q <= slv_cyc_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            sel_q     <= sel_d;
            m_dat_q   <= m_dat_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            irq_q     <= irq_d;
`ifdef WB_XBAR_TIMEOUT_EN
            timer_q   <= timer_d;
`endif
        end
    end

    assign wbs_m_ack_o = ack_q;
    assign wbs_m_err_o = err_q;
    assign wbs_m_dat_o = m_dat_q;
    assign wbs_s_cyc_o = slv_cyc_q;
    assign wbs_s_stb_o = slv_cyc_q;
    assign wbs_s_we_o  = we_q;
    assign wbs_s_adr_o = adr_q;
    assign wbs_s_dat_o = wdat_q;
    assign wbs_s_sel_o = sel_q;
    assign err_irq     = irq_q;

endmodule

// File: tb/tb_wishbone_1mst_to_nslv.sv
// Scoreboard bench for wishbone_1mst_to_nslv: 4 slaves, slave 3 overlaps slave 0 (lower index wins).
module tb_wishbone_1mst_to_nslv;

    localparam int          NS       = 4;
    localparam int          TMO      = 8;
    localparam logic [31:0] UNM_DATA = 32'hBADA_DD00;
    localparam logic [31:0] TMO_DATA = 32'hDEAD_0000;

    localparam logic [31:0] BASE_T [NS] = '{32'h3000_0000, 32'h3001_0000, 32'h3002_0000, 32'h3000_0000};
    localparam logic [31:0] MASK_T [NS] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFC_0000};

    localparam logic [511:0] P_ADDR = {{12{32'h3000_0000}}, 32'h3000_0000, 32'h3002_0000, 32'h3001_0000, 32'h3000_0000};
    localparam logic [511:0] P_MASK = {{12{32'hFFFF_0000}}, 32'hFFFC_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          lat;
        int          t_issue;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              m_cyc, m_stb, m_we;
    logic [31:0]       m_adr, m_wdat;
    logic [3:0]        m_sel;
    logic              m_ack, m_err, irq;
    logic [31:0]       m_rdat;
    logic [NS-1:0]     s_cyc, s_stb, s_ack;
    logic              s_we;
    logic [31:0]       s_adr, s_wdat;
    logic [3:0]        s_sel;
    logic [32*NS-1:0]  s_rdat;

    int                n_vec = 0;
    int                n_err = 0;
    int                n_acks = 0;
    int                cyc_cnt = 0;
    int                t_issue = 0;
    int                cur_target = -1;
    int                cur_dly = -1;
    int                stb_cnt [NS];
    logic [31:0]       slv_rdata [NS];
    logic [NS-1:0]     noise = '0;
    logic [NS-1:0]     exp_onehot = '0;
    logic [31:0]       exp_adr = '0, exp_wdat = '0;
    logic [3:0]        exp_sel = '0;
    logic              exp_we = 1'b0;
    exp_t              exp_q [$];
    exp_t              mon_e;

    wishbone_1mst_to_nslv #(
        .NB_SLV  (NS),
        .ADDR_S  (P_ADDR),
        .MASK_S  (P_MASK),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wbs_m_cyc_i (m_cyc),
        .wbs_m_stb_i (m_stb),
        .wbs_m_we_i  (m_we),
        .wbs_m_adr_i (m_adr),
        .wbs_m_dat_i (m_wdat),
        .wbs_m_sel_i (m_sel),
        .wbs_m_ack_o (m_ack),
        .wbs_m_err_o (m_err),
        .wbs_m_dat_o (m_rdat),
        .wbs_s_cyc_o (s_cyc),
        .wbs_s_stb_o (s_stb),
        .wbs_s_we_o  (s_we),
        .wbs_s_adr_o (s_adr),
        .wbs_s_dat_o (s_wdat),
        .wbs_s_sel_o (s_sel),
        .wbs_s_dat_i (s_rdat),
        .wbs_s_ack_i (s_ack),
        .err_irq     (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Slaves: ack once the strobe has been held cur_dly cycles; unselected slaves babble random acks.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NS; i++) begin
            if (!rst_n) stb_cnt[i] <= 0;
            else        stb_cnt[i] <= s_stb[i] ? stb_cnt[i] + 1 : 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NS; i++)
            noise[i] <= (i != cur_target) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            s_ack[i]          = noise[i] | (s_stb[i] && cur_dly >= 0 && stb_cnt[i] == cur_dly);
            s_rdat[32*i +: 32] = slv_rdata[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & MASK_T[i]) == (BASE_T[i] & MASK_T[i])) return i;
        return -1;
    endfunction

    // Monitor: pop the scoreboard on each master ack; check broadcast while any strobe is up.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_ack) begin
                n_acks++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'(m_ack), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rdata",   m_rdat, mon_e.dat);
                    chk("err",     32'(m_err), 32'(mon_e.err));
                    chk("err_irq", 32'(irq), 32'(mon_e.err));
                    chk("latency", 32'(cyc_cnt - mon_e.t_issue), 32'(mon_e.lat));
                end
            end else if (m_err || irq) begin
                chk("err_without_ack", 32'({m_err, irq}), 32'd0);
            end
            if (|s_stb) begin
                chk("slave_stb", 32'(s_stb), 32'(exp_onehot));
                chk("slave_cyc", 32'(s_cyc), 32'(exp_onehot));
                chk("bcast_adr", s_adr, exp_adr);
                chk("bcast_dat", s_wdat, exp_wdat);
                chk("bcast_sel", 32'(s_sel), 32'(exp_sel));
                chk("bcast_we",  32'(s_we), 32'(exp_we));
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input int dly);
        for (int i = 0; i < NS; i++) slv_rdata[i] = $urandom();
        cur_target = model_decode(a);
        cur_dly    = dly;
        exp_onehot = (cur_target < 0) ? '0 : NS'(1 << cur_target);
        exp_adr    = a;
        exp_wdat   = d;
        exp_sel    = s;
        exp_we     = w;
        @(negedge clk);
        m_cyc  = 1'b1;
        m_stb  = 1'b1;
        m_we   = w;
        m_adr  = a;
        m_wdat = d;
        m_sel  = s;
        t_issue = cyc_cnt;
    endtask

    task automatic drop_master();
        m_cyc      = 1'b0;
        m_stb      = 1'b0;
        cur_dly    = -1;
        cur_target = -1;
    endtask

    task automatic run_txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input int dly);
        exp_t e;
        int   tgt;
        int   n;
        tgt = model_decode(a);
        issue(a, w, d, s, dly);
        if (tgt < 0)                    e = '{UNM_DATA, 1'b1, 1, t_issue};
        else if (dly < 0 || dly >= TMO) e = '{TMO_DATA, 1'b1, TMO + 1, t_issue};
        else                            e = '{slv_rdata[tgt], 1'b0, dly + 2, t_issue};
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_ack && n < 400);
        if (!m_ack) chk("ack_wait_expired", 32'(m_ack), 32'd1);
        drop_master();
    endtask

    initial begin
        int          acks0;
        int          r;
        int          d;
        logic [31:0] a;

        for (int i = 0; i < NS; i++) slv_rdata[i] = '0;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        m_adr = '0; m_wdat = '0; m_sel = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_ack",  32'(m_ack), 32'd0);
        chk("rst_m_err",  32'(m_err), 32'd0);
        chk("rst_m_dat",  m_rdat, 32'd0);
        chk("rst_s_strb", 32'({s_cyc, s_stb}), 32'd0);
        chk("rst_s_bus",  32'({s_we, s_sel}) | s_adr | s_wdat, 32'd0);
        chk("rst_irq",    32'(irq), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(32'h3002_0004, 1'b0, 32'h0, 4'hF, 0);
        run_txn(32'h3003_0000, 1'b1, 32'hA5A5_A5A5, 4'b0011, 5);
        run_txn(32'h4000_0000, 1'b0, 32'h0, 4'hF, 0);
        run_txn(32'h3000_1234, 1'b0, 32'h0, 4'hF, 1);

`ifdef WB_XBAR_TIMEOUT_EN
        run_txn(32'h3001_0010, 1'b0, 32'h0, 4'hF, -1);
        run_txn(32'h3001_0020, 1'b0, 32'h0, 4'hF, TMO - 1);
`else
        issue(32'h3001_0010, 1'b0, 32'h0, 4'hF, -1);
        acks0 = n_acks;
        repeat (100) @(negedge clk);
        chk("no_ack_100", 32'(n_acks), 32'(acks0));
        chk("stb1_held", 32'(s_stb), 32'b0010);
        drop_master();
        repeat (2) @(negedge clk);
        chk("stb_clear_after_wait", 32'(s_stb), 32'd0);
`endif

        issue(32'h3000_0008, 1'b0, 32'h0, 4'hF, -1);
        repeat (3) @(negedge clk);
        acks0 = n_acks;
        drop_master();
        repeat (3) @(negedge clk);
        chk("abort_stb_clear", 32'(s_stb), 32'd0);
        chk("abort_no_ack", 32'(n_acks), 32'(acks0));
        run_txn(32'h3000_0010, 1'b0, 32'h0, 4'hF, 2);

        issue(32'h3001_0000, 1'b1, 32'h1111_2222, 4'hF, -1);
        repeat (3) @(negedge clk);
        acks0 = n_acks;
        rst_n = 1'b0;
        #1;
        chk("reset_stb_clear", 32'(s_stb), 32'd0);
        chk("reset_no_ack", 32'(m_ack), 32'd0);
        drop_master();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_no_late_ack", 32'(n_acks), 32'(acks0));
        run_txn(32'h3000_0004, 1'b0, 32'h0, 4'hF, 0);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 5);
            if (r < 4)       a = {16'(32'h3000 + r), 16'($urandom())};
            else if (r == 4) a = {16'h3004, 16'($urandom())};
            else             a = $urandom() | 32'h8000_0000;
            d = $urandom_range(0, 6);
`ifdef WB_XBAR_TIMEOUT_EN
            if ((k % 8) == 3) d = TMO + $urandom_range(0, 2);
`endif
            run_txn(a, 1'($urandom_range(0, 1)), $urandom(), 4'($urandom_range(0, 15)), d);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
